// File: rtl/cla_mul_seq.sv
// cla_mul_seq: 16x16 unsigned shift-add multiplier sequencing an external CLA.
// Optional CLA_MUL_ZERO_BYPASS_EN: zero operand skips straight to DONE.
module cla_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   cla_A,
  output logic [WIDTH-1:0]   cla_B,
  output logic               cla_sub,
  input  logic [WIDTH-1:0]   cla_Sum
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mcand, p_hi, p_lo, s;
  logic [CW-1:0] cnt;
  logic accept, zero, add, c;
  assign accept = start && state != CALC;
`ifdef CLA_MUL_ZERO_BYPASS_EN
  assign zero = op_a == '0 || op_b == '0;
`else
  assign zero = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == CALC ? (cnt == CW'(WIDTH - 1) ? DONE : CALC)
            : accept ? (zero ? DONE : CALC) : IDLE;
  always_comb begin
    busy = state == CALC;
    done = state == DONE;
  end
  assign add     = p_lo[0];
  assign cla_A   = p_hi;
  assign cla_B   = add ? mcand : '0;
  assign cla_sub = 1'b0;
  // The CLA has no carry-out port; recover it from the operand and sum MSBs.
  assign c = add & ((p_hi[WIDTH-1] & mcand[WIDTH-1]) |
                    ((p_hi[WIDTH-1] | mcand[WIDTH-1]) & ~cla_Sum[WIDTH-1]));
  assign s = add ? cla_Sum : p_hi;
  assign product = {p_hi, p_lo};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= op_a;
      p_hi  <= '0;
      p_lo  <= zero ? '0 : op_b;
      cnt   <= '0;
    end else if (state == CALC) begin
      {p_hi, p_lo} <= {c, s, p_lo[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
endmodule
